// File: rtl/main.sv
// Registered modular adder/subtractor, modulus m in [9,15].
// Operands are reduced mod m first; result is registered.
module main #(
  parameter logic [3:0] m = 4'b1100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic s,
  input  logic x3,
  input  logic x2,
  input  logic x1,
  input  logic x0,
  input  logic y3,
  input  logic y2,
  input  logic y1,
  input  logic y0,
  output logic z3,
  output logic z2,
  output logic z1,
  output logic z0
);

  if ((m < 4'd9) || (m > 4'd15)) begin : g_bad_m
    $error("main: modulus m must be in 9..15");
  end

  localparam logic [4:0] MM = {1'b0, m};

  logic [4:0] xw;
  logic [4:0] yw;
  logic [4:0] xr;
  logic [4:0] yr;
  logic [4:0] sum;
  logic [4:0] dif;
  logic       borrow;
  logic       wrap;
  logic [4:0] res;
  logic [3:0] z_q;

  assign xw = {1'b0, x3, x2, x1, x0};
  assign yw = {1'b0, y3, y2, y1, y0};

  // Operands never exceed 2m-1, so one conditional subtract reduces them.
  always_comb begin
    xr = xw;
    yr = yw;
    if (xw >= MM) xr = xw - MM;
    if (yw >= MM) yr = yw - MM;
  end

  assign sum    = xr + yr;
  assign dif    = xr - yr;
  assign borrow = xr < yr;
  assign wrap   = sum >= MM;

  // Fold the raw sum/difference back into [0, m-1].
  always_comb begin
    res = 5'd0;
    unique case (1'b1)
      (!s &&  wrap):   res = sum - MM;
      (!s && !wrap):   res = sum;
      ( s &&  borrow): res = dif + MM;
      ( s && !borrow): res = dif;
      default:         res = 5'd0;
    endcase
  end

  // Result register; reset clears it regardless of the clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) z_q <= 4'd0;
    else        z_q <= res[3:0];
  end

  assign {z3, z2, z1, z0} = z_q;

endmodule

// File: tb/tb_main.sv
// Bench for main: directed vectors and exhaustive sweeps
// for m = 12 (default), 9 and 15.
module tb_main;

  logic       clk;
  logic       rst_n;
  logic       s;
  logic [3:0] xv;
  logic [3:0] yv;
  logic [3:0] z12;
  logic [3:0] z9;
  logic [3:0] z15;

  int checks;
  int failures;

  main u_m12 (
    .clk(clk), .rst_n(rst_n), .s(s),
    .x3(xv[3]), .x2(xv[2]), .x1(xv[1]), .x0(xv[0]),
    .y3(yv[3]), .y2(yv[2]), .y1(yv[1]), .y0(yv[0]),
    .z3(z12[3]), .z2(z12[2]), .z1(z12[1]), .z0(z12[0])
  );

  main #(.m(4'b1001)) u_m9 (
    .clk(clk), .rst_n(rst_n), .s(s),
    .x3(xv[3]), .x2(xv[2]), .x1(xv[1]), .x0(xv[0]),
    .y3(yv[3]), .y2(yv[2]), .y1(yv[1]), .y0(yv[0]),
    .z3(z9[3]), .z2(z9[2]), .z1(z9[1]), .z0(z9[0])
  );

  main #(.m(4'b1111)) u_m15 (
    .clk(clk), .rst_n(rst_n), .s(s),
    .x3(xv[3]), .x2(xv[2]), .x1(xv[1]), .x0(xv[0]),
    .y3(yv[3]), .y2(yv[2]), .y1(yv[1]), .y0(yv[0]),
    .z3(z15[3]), .z2(z15[2]), .z1(z15[1]), .z0(z15[0])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] got,
                     input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic apply(input logic op, input int a, input int b);
    @(negedge clk);
    s  = op;
    xv = a[3:0];
    yv = b[3:0];
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] ref_z(input int md, input logic op,
                                       input int a, input int b);
    int r;
    if (op) r = ((a % md) - (b % md) + md) % md;
    else    r = ((a % md) + (b % md)) % md;
    return r[3:0];
  endfunction

  typedef struct {
    string tag;
    int    md;
    logic  op;
    int    a;
    int    b;
    int    z;
  } vec_t;

  vec_t dir[$];

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    s        = 1'b0;
    xv       = 4'd7;
    yv       = 4'd8;
    #2;
    chk("reset_z12", z12, 4'd0);
    chk("reset_z9", z9, 4'd0);
    @(posedge clk);
    #1;
    chk("reset_held", z12, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;

    dir.push_back('{"add_7_8",     12, 1'b0, 7, 8, 3});
    dir.push_back('{"add_11_11",   12, 1'b0, 11, 11, 10});
    dir.push_back('{"add_5_6",     12, 1'b0, 5, 6, 11});
    dir.push_back('{"sub_3_5",     12, 1'b1, 3, 5, 10});
    dir.push_back('{"sub_9_4",     12, 1'b1, 9, 4, 5});
    dir.push_back('{"sub_0_11",    12, 1'b1, 0, 11, 1});
    dir.push_back('{"sub_6_6",     12, 1'b1, 6, 6, 0});
    dir.push_back('{"m9_add_8_8",  9,  1'b0, 8, 8, 7});
    dir.push_back('{"m9_sub_0_8",  9,  1'b1, 0, 8, 1});
    dir.push_back('{"oor_add_15_14", 12, 1'b0, 15, 14, 5});
    dir.push_back('{"oor_sub_12_13", 12, 1'b1, 12, 13, 11});
    dir.push_back('{"m15_add_14_14", 15, 1'b0, 14, 14, 13});
    dir.push_back('{"m15_sub_0_14",  15, 1'b1, 0, 14, 1});

    foreach (dir[i]) begin
      logic [3:0] e;
      e = dir[i].z[3:0];
      apply(dir[i].op, dir[i].a, dir[i].b);
      if (dir[i].md == 12)     chk(dir[i].tag, z12, e);
      else if (dir[i].md == 9) chk(dir[i].tag, z9, e);
      else                     chk(dir[i].tag, z15, e);
    end

    for (int op = 0; op < 2; op++)
      for (int a = 0; a < 12; a++)
        for (int b = 0; b < 12; b++) begin
          apply(op[0], a, b);
          chk("exh_m12", z12, ref_z(12, op[0], a, b));
        end

    for (int op = 0; op < 2; op++)
      for (int a = 0; a < 9; a++)
        for (int b = 0; b < 9; b++) begin
          apply(op[0], a, b);
          chk("exh_m9", z9, ref_z(9, op[0], a, b));
        end

    for (int op = 0; op < 2; op++)
      for (int a = 0; a < 15; a++)
        for (int b = 0; b < 15; b++) begin
          apply(op[0], a, b);
          chk("exh_m15", z15, ref_z(15, op[0], a, b));
        end

    apply(1'b0, 7, 8);
    chk("rst_seq_load", z12, 4'd3);
    @(negedge clk);
    xv = 4'd1;
    yv = 4'd1;
    #1;
    chk("between_edges_hold", z12, 4'd3);
    xv = 4'd7;
    yv = 4'd8;
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_async_z12", z12, 4'd0);
    chk("rst_async_z15", z15, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_release", z12, 4'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
